// File: rtl/mem_port_arbiter.sv
// Two-port valid/ready arbiter in front of a single data-memory port.
// The winning request is latched so the memory sees stable fields and a clean rising valid edge.
module mem_port_arbiter #(
    parameter int ADDR_W    = 18,
    parameter int PRIO_MODE = 0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_P0_VALID,
    output logic              o_P0_READY,
    input  logic [ADDR_W-1:0] i_P0_ADDR,
    input  logic [31:0]       i_P0_WDATA,
    input  logic [3:0]        i_P0_BMASK,
    input  logic              i_P0_WREN,
    output logic [31:0]       o_P0_RDATA,
    input  logic              i_P1_VALID,
    output logic              o_P1_READY,
    input  logic [ADDR_W-1:0] i_P1_ADDR,
    input  logic [31:0]       i_P1_WDATA,
    input  logic [3:0]        i_P1_BMASK,
    input  logic              i_P1_WREN,
    output logic [31:0]       o_P1_RDATA,
    output logic              o_M_VALID,
    input  logic              i_M_READY,
    output logic [ADDR_W-1:0] o_M_ADDR,
    output logic [31:0]       o_M_WDATA,
    output logic [3:0]        o_M_BMASK,
    output logic              o_M_WREN,
    input  logic [31:0]       i_M_RDATA,
    output logic [1:0]        o_GRANT
);
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t            state_q, state_d;
    logic              lastGrant_q, lastGrant_d;
    logic [1:0]        grant_q, grant_d;
    logic              mValid_q, mValid_d;
    logic [ADDR_W-1:0] mAddr_q, mAddr_d;
    logic [31:0]       mWdata_q, mWdata_d;
    logic [3:0]        mBmask_q, mBmask_d;
    logic              mWren_q, mWren_d;
    logic              p0Ready_q, p0Ready_d;
    logic              p1Ready_q, p1Ready_d;
    logic [31:0]       p0Rdata_q, p0Rdata_d;
    logic [31:0]       p1Rdata_q, p1Rdata_d;
    logic              pick1;

    // lastGrant_q holds the most recently served port; on a tie the other one wins.
    always_comb begin
        if (PRIO_MODE == 1) begin
            pick1 = !i_P0_VALID;
        end else if (i_P0_VALID && i_P1_VALID) begin
            pick1 = !lastGrant_q;
        end else begin
            pick1 = !i_P0_VALID;
        end
    end

    always_comb begin
        state_d     = state_q;
        lastGrant_d = lastGrant_q;
        grant_d     = grant_q;
        mValid_d    = mValid_q;
        mAddr_d     = mAddr_q;
        mWdata_d    = mWdata_q;
        mBmask_d    = mBmask_q;
        mWren_d     = mWren_q;
        p0Ready_d   = 1'b0;
        p1Ready_d   = 1'b0;
        p0Rdata_d   = p0Rdata_q;
        p1Rdata_d   = p1Rdata_q;

        case (state_q)
            IDLE: begin
                if (i_P0_VALID || i_P1_VALID) begin
                    mAddr_d     = pick1 ? i_P1_ADDR  : i_P0_ADDR;
                    mWdata_d    = pick1 ? i_P1_WDATA : i_P0_WDATA;
                    mBmask_d    = pick1 ? i_P1_BMASK : i_P0_BMASK;
                    mWren_d     = pick1 ? i_P1_WREN  : i_P0_WREN;
                    grant_d     = pick1 ? 2'b10 : 2'b01;
                    lastGrant_d = pick1;
                    mValid_d    = 1'b1;
                    state_d     = BUSY;
                end
            end
            BUSY: begin
                if (i_M_READY) begin
                    if (!mWren_q && grant_q[0]) p0Rdata_d = i_M_RDATA;
                    if (!mWren_q && grant_q[1]) p1Rdata_d = i_M_RDATA;
                    p0Ready_d = grant_q[0];
                    p1Ready_d = grant_q[1];
                    mValid_d  = 1'b0;
                    state_d   = RESP;
                end
            end
            RESP: begin
                // The owner's valid may still be high here; it belongs to the finished handshake.
                grant_d = 2'b00;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            lastGrant_q <= 1'b1;
            grant_q     <= 2'b00;
            mValid_q    <= 1'b0;
            mAddr_q     <= '0;
            mWdata_q    <= '0;
            mBmask_q    <= '0;
            mWren_q     <= 1'b0;
            p0Ready_q   <= 1'b0;
            p1Ready_q   <= 1'b0;
            p0Rdata_q   <= '0;
            p1Rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            lastGrant_q <= lastGrant_d;
            grant_q     <= grant_d;
            mValid_q    <= mValid_d;
            mAddr_q     <= mAddr_d;
            mWdata_q    <= mWdata_d;
            mBmask_q    <= mBmask_d;
            mWren_q     <= mWren_d;
            p0Ready_q   <= p0Ready_d;
            p1Ready_q   <= p1Ready_d;
            p0Rdata_q   <= p0Rdata_d;
            p1Rdata_q   <= p1Rdata_d;
        end
    end

    assign o_M_VALID  = mValid_q;
    assign o_M_ADDR   = mAddr_q;
    assign o_M_WDATA  = mWdata_q;
    assign o_M_BMASK  = mBmask_q;
    assign o_M_WREN   = mWren_q;
    assign o_GRANT    = grant_q;
    assign o_P0_READY = p0Ready_q;
    assign o_P1_READY = p1Ready_q;
    assign o_P0_RDATA = p0Rdata_q;
    assign o_P1_RDATA = p1Rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: instance 0 is round-robin, instance 1 fixed priority.
// A small memory model answers each instance; expected transactions are queued in grant order.
module tb_mem_port_arbiter;
    localparam int ADDR_W = 18;

    typedef struct {
        int                port;
        logic [ADDR_W-1:0] addr;
        logic [31:0]       wdata;
        logic [3:0]        bmask;
        logic              wren;
    } txn_t;

    logic clock = 1'b0;
    logic rstN;

    logic              pValid [2][2];
    logic [ADDR_W-1:0] pAddr  [2][2];
    logic [31:0]       pWdata [2][2];
    logic [3:0]        pBmask [2][2];
    logic              pWren  [2][2];
    wire               pReady [2][2];
    wire  [31:0]       pRdata [2][2];
    wire               mValid [2];
    wire  [ADDR_W-1:0] mAddr  [2];
    wire  [31:0]       mWdata [2];
    wire  [3:0]        mBmask [2];
    wire               mWren  [2];
    wire  [1:0]        grant  [2];
    logic              mReady [2];
    logic [31:0]       mRdata [2];

    int   total = 0;
    int   bad   = 0;
    txn_t sbq [2][$];
    logic [31:0] expRdata [2][2];
    int   waitStates [2];
    int   waitCnt [2];
    int   gap [2];
    bit   prevValid [2];
    bit   prevReady [2];
    int   doneCnt [2];
    txn_t monTxn;
    int   latA, latB, base;
    bit   got6;
    int   lat6;

    initial forever #5 clock = ~clock;

    for (genvar g = 0; g < 2; g++) begin : gDut
        mem_port_arbiter #(.ADDR_W(ADDR_W), .PRIO_MODE(g)) uDut (
            .i_clk      (clock),
            .i_rst_n    (rstN),
            .i_P0_VALID (pValid[g][0]),
            .o_P0_READY (pReady[g][0]),
            .i_P0_ADDR  (pAddr[g][0]),
            .i_P0_WDATA (pWdata[g][0]),
            .i_P0_BMASK (pBmask[g][0]),
            .i_P0_WREN  (pWren[g][0]),
            .o_P0_RDATA (pRdata[g][0]),
            .i_P1_VALID (pValid[g][1]),
            .o_P1_READY (pReady[g][1]),
            .i_P1_ADDR  (pAddr[g][1]),
            .i_P1_WDATA (pWdata[g][1]),
            .i_P1_BMASK (pBmask[g][1]),
            .i_P1_WREN  (pWren[g][1]),
            .o_P1_RDATA (pRdata[g][1]),
            .o_M_VALID  (mValid[g]),
            .i_M_READY  (mReady[g]),
            .o_M_ADDR   (mAddr[g]),
            .o_M_WDATA  (mWdata[g]),
            .o_M_BMASK  (mBmask[g]),
            .o_M_WREN   (mWren[g]),
            .i_M_RDATA  (mRdata[g]),
            .o_GRANT    (grant[g])
        );
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%h want=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] memWord(input logic [ADDR_W-1:0] a);
        if (a == 18'h10) return 32'hDEADBEEF;
        return {14'h2A5, a} ^ 32'h0F0F_0F0F;
    endfunction

    function automatic txn_t mkTxn(input int port, input logic [ADDR_W-1:0] addr,
                                   input logic [31:0] wdata, input logic [3:0] bmask, input logic wren);
        txn_t t;
        t.port  = port;
        t.addr  = addr;
        t.wdata = wdata;
        t.bmask = bmask;
        t.wren  = wren;
        return t;
    endfunction

    // Memory model: ready after waitStates BUSY cycles; ready is also left high while
    // idle, with junk data, so a stray ack outside BUSY must be ignored.
    always @(negedge clock) begin
        for (int g = 0; g < 2; g++) begin
            if (mValid[g] === 1'b1) begin
                mReady[g] = (waitCnt[g] >= waitStates[g]);
                mRdata[g] = (waitCnt[g] >= waitStates[g]) ? memWord(mAddr[g]) : 32'hBADD_0000;
                waitCnt[g]++;
            end else begin
                mReady[g]  = 1'b1;
                mRdata[g]  = 32'hF00D_F00D;
                waitCnt[g] = 0;
            end
        end
    end

    // Scoreboard monitor: checks held memory fields, valid gaps, grants and completions.
    always @(negedge clock) begin
        if (rstN !== 1'b1) begin
            for (int g = 0; g < 2; g++) begin
                gap[g]       = 99;
                prevValid[g] = 1'b0;
                prevReady[g] = 1'b0;
            end
        end else begin
            for (int g = 0; g < 2; g++) begin
                logic [1:0] rv;
                rv = {pReady[g][1], pReady[g][0]};
                if (mValid[g] === 1'b1) begin
                    if (!prevValid[g]) checkOutput("valid_gap_ge2", gap[g] >= 2, 1);
                    checkOutput("busy_has_txn", sbq[g].size() != 0, 1);
                    if (sbq[g].size() != 0) begin
                        checkOutput("m_addr",  mAddr[g],  sbq[g][0].addr);
                        checkOutput("m_wdata", mWdata[g], sbq[g][0].wdata);
                        checkOutput("m_bmask", mBmask[g], sbq[g][0].bmask);
                        checkOutput("m_wren",  mWren[g],  sbq[g][0].wren);
                        checkOutput("busy_grant", grant[g], (sbq[g][0].port == 1) ? 2 : 1);
                    end
                    gap[g] = 0;
                end else begin
                    gap[g]++;
                end
                prevValid[g] = (mValid[g] === 1'b1);

                if (rv != 2'b00) begin
                    checkOutput("ready_single", prevReady[g], 0);
                    checkOutput("ready_has_txn", sbq[g].size() != 0, 1);
                    if (sbq[g].size() != 0) begin
                        monTxn = sbq[g].pop_front();
                        checkOutput("ready_owner", rv, (monTxn.port == 1) ? 2 : 1);
                        checkOutput("resp_grant", grant[g], (monTxn.port == 1) ? 2 : 1);
                        checkOutput("resp_m_valid", mValid[g], 0);
                        if (!monTxn.wren) expRdata[g][monTxn.port] = memWord(monTxn.addr);
                        checkOutput("rdata_p0", pRdata[g][0], expRdata[g][0]);
                        checkOutput("rdata_p1", pRdata[g][1], expRdata[g][1]);
                        doneCnt[g]++;
                    end
                end else if (mValid[g] !== 1'b1) begin
                    checkOutput("idle_grant", grant[g], 0);
                end
                prevReady[g] = (rv != 2'b00);
            end
        end
    end

    // Drives one request, holds it until READY, keeps it through RESP, then releases it.
    task automatic applyStimulus(input int g, input int port, input logic [ADDR_W-1:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] bmask,
                                 input logic wren, output int lat);
        bit got;
        got = 1'b0;
        lat = 0;
        pAddr[g][port]  = addr;
        pWdata[g][port] = wdata;
        pBmask[g][port] = bmask;
        pWren[g][port]  = wren;
        pValid[g][port] = 1'b1;
        for (int i = 1; i <= 60 && !got; i++) begin
            @(negedge clock);
            if (pReady[g][port] === 1'b1) begin
                got = 1'b1;
                lat = i;
            end
        end
        checkOutput("req_served", got, 1);
        @(negedge clock);
        pValid[g][port] = 1'b0;
    endtask

    task automatic checkReset(input int g);
        checkOutput("rst_m_valid", mValid[g], 0);
        checkOutput("rst_m_addr",  mAddr[g],  0);
        checkOutput("rst_m_wdata", mWdata[g], 0);
        checkOutput("rst_m_bmask", mBmask[g], 0);
        checkOutput("rst_m_wren",  mWren[g],  0);
        checkOutput("rst_p0_ready", pReady[g][0], 0);
        checkOutput("rst_p1_ready", pReady[g][1], 0);
        checkOutput("rst_p0_rdata", pRdata[g][0], 0);
        checkOutput("rst_p1_rdata", pRdata[g][1], 0);
        checkOutput("rst_grant", grant[g], 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rstN = 1'b0;
        for (int g = 0; g < 2; g++) begin
            waitStates[g] = 0;
            waitCnt[g]    = 0;
            doneCnt[g]    = 0;
            mReady[g]     = 1'b0;
            mRdata[g]     = 32'h0;
            for (int p = 0; p < 2; p++) begin
                pValid[g][p]   = 1'b0;
                pAddr[g][p]    = '0;
                pWdata[g][p]   = '0;
                pBmask[g][p]   = '0;
                pWren[g][p]    = 1'b0;
                expRdata[g][p] = '0;
            end
        end
        repeat (3) @(negedge clock);
        checkReset(0);
        checkReset(1);
        #2 rstN = 1'b1;
        @(negedge clock);

        $display("[TB] single read on port 0");
        sbq[0].push_back(mkTxn(0, 18'h00010, 32'h0, 4'hF, 1'b0));
        applyStimulus(0, 0, 18'h00010, 32'h0, 4'hF, 1'b0, latA);
        checkOutput("t1_latency", latA, 2);
        checkOutput("t1_p0_rdata", pRdata[0][0], 32'hDEADBEEF);
        checkOutput("t1_p1_rdata", pRdata[0][1], 32'h0);

        $display("[TB] port 1 write with wait states");
        waitStates[0] = 5;
        sbq[0].push_back(mkTxn(1, 18'h00104, 32'h12345678, 4'b0011, 1'b1));
        applyStimulus(0, 1, 18'h00104, 32'h12345678, 4'b0011, 1'b1, latA);
        checkOutput("t2_latency", latA, 7);
        checkOutput("t2_p1_rdata", pRdata[0][1], 32'h0);
        checkOutput("t2_p0_rdata", pRdata[0][0], 32'hDEADBEEF);

        $display("[TB] round-robin with both ports requesting");
        waitStates[0] = 1;
        base = doneCnt[0];
        sbq[0].push_back(mkTxn(0, 18'h00200, 32'h0, 4'hF, 1'b0));
        sbq[0].push_back(mkTxn(1, 18'h00300, 32'h0, 4'hF, 1'b0));
        sbq[0].push_back(mkTxn(0, 18'h00208, 32'hA5A55A5A, 4'b1100, 1'b1));
        sbq[0].push_back(mkTxn(1, 18'h0030C, 32'h0, 4'hF, 1'b0));
        fork
            begin
                applyStimulus(0, 0, 18'h00200, 32'h0, 4'hF, 1'b0, latA);
                applyStimulus(0, 0, 18'h00208, 32'hA5A55A5A, 4'b1100, 1'b1, latA);
            end
            begin
                applyStimulus(0, 1, 18'h00300, 32'h0, 4'hF, 1'b0, latB);
                applyStimulus(0, 1, 18'h0030C, 32'h0, 4'hF, 1'b0, latB);
            end
        join
        checkOutput("t3_count", doneCnt[0] - base, 4);

        $display("[TB] fixed priority with port 0 re-requesting");
        base = doneCnt[1];
        sbq[1].push_back(mkTxn(0, 18'h00400, 32'h0, 4'hF, 1'b0));
        sbq[1].push_back(mkTxn(0, 18'h00404, 32'h0, 4'hF, 1'b0));
        sbq[1].push_back(mkTxn(0, 18'h00408, 32'hCAFEF00D, 4'b0101, 1'b1));
        sbq[1].push_back(mkTxn(1, 18'h00500, 32'h0, 4'hF, 1'b0));
        fork
            begin
                applyStimulus(1, 0, 18'h00400, 32'h0, 4'hF, 1'b0, latA);
                applyStimulus(1, 0, 18'h00404, 32'h0, 4'hF, 1'b0, latA);
                applyStimulus(1, 0, 18'h00408, 32'hCAFEF00D, 4'b0101, 1'b1, latA);
            end
            begin
                applyStimulus(1, 1, 18'h00500, 32'h0, 4'hF, 1'b0, latB);
            end
        join
        checkOutput("t4_count", doneCnt[1] - base, 4);

        $display("[TB] port inputs change during BUSY");
        waitStates[0] = 3;
        sbq[0].push_back(mkTxn(0, 18'h00040, 32'h0, 4'hF, 1'b0));
        fork
            applyStimulus(0, 0, 18'h00040, 32'h0, 4'hF, 1'b0, latA);
            begin
                repeat (2) @(negedge clock);
                pAddr[0][0]  = 18'h00080;
                pWdata[0][0] = 32'h0BAD0BAD;
                pWren[0][0]  = 1'b1;
                @(negedge clock);
                checkOutput("t5_addr_hold", mAddr[0], 18'h00040);
            end
        join
        checkOutput("t5_p0_rdata", pRdata[0][0], memWord(18'h00040));

        $display("[TB] reset during BUSY");
        waitStates[0] = 20;
        sbq[0].push_back(mkTxn(0, 18'h00060, 32'h0, 4'hF, 1'b0));
        pAddr[0][0]  = 18'h00060;
        pWdata[0][0] = 32'h0;
        pBmask[0][0] = 4'hF;
        pWren[0][0]  = 1'b0;
        pValid[0][0] = 1'b1;
        repeat (2) @(negedge clock);
        checkOutput("t6_busy", mValid[0], 1);
        #2 rstN = 1'b0;
        @(negedge clock);
        checkReset(0);
        sbq[0].delete();
        for (int p = 0; p < 2; p++) expRdata[0][p] = '0;
        waitStates[0] = 0;
        sbq[0].push_back(mkTxn(0, 18'h00060, 32'h0, 4'hF, 1'b0));
        #2 rstN = 1'b1;
        got6 = 1'b0;
        lat6 = 0;
        for (int i = 1; i <= 20 && !got6; i++) begin
            @(negedge clock);
            if (pReady[0][0] === 1'b1) begin
                got6 = 1'b1;
                lat6 = i;
            end
        end
        checkOutput("t6_served", got6, 1);
        checkOutput("t6_latency", lat6, 2);
        @(negedge clock);
        pValid[0][0] = 1'b0;
        checkOutput("t6_p0_rdata", pRdata[0][0], memWord(18'h00060));

        repeat (4) @(negedge clock);
        checkOutput("sb_left_0", sbq[0].size(), 0);
        checkOutput("sb_left_1", sbq[1].size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
